// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and constants.
// State encoding, port ids, width defaults.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [15:0] UART_ADDR = 16'h8010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } arb_port_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// mem_arbiter start-acknowledge watchdog.
// Counts cycles while enabled; flags when LIMIT is reached.
module arb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 2);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT));

  // restart on load, saturate at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data port arbiter in front
// of a shared memory/UART controller.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int START_TIMEOUT  = 255,
  parameter int MAX_DATA_BURST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              err,
  output logic              ctl_need,
  output logic              ctl_rd,
  output logic              ctl_wr,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_done,
  input  logic [DATA_W-1:0] ctl_result
);

  localparam int BW = $clog2(MAX_DATA_BURST + 2);

  arb_state_t    state;
  arb_state_t    state_n;
  arb_port_t     port;
  logic          err_q;
  logic [BW-1:0] burst;

  logic dm_req;
  logic pick_dm;
  logic grant;
  logic g_rd;
  logic g_wr;
  logic tmo_load;
  logic tmo_en;
  logic tmo_exp;
  logic capture;
  logic time_out;

  assign dm_req  = dm_rd | dm_wr;
  assign pick_dm = dm_req &
    (~if_req | (burst < BW'(MAX_DATA_BURST)));
  assign grant   = (state == IDLE) &
    (dm_req | if_req);

  assign if_stall = if_req & ~if_ack & ~rst;
  assign dm_stall = dm_req & ~dm_ack & ~rst;

  arb_timeout_cnt #(
    .LIMIT(START_TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load),
    .en     (tmo_en),
    .expired(tmo_exp)
  );

  // decode the granted operation; write wins over read
  always_comb begin
    g_rd = 1'b1;
    g_wr = 1'b0;
    unique case (1'b1)
      pick_dm & dm_wr: begin
        g_rd = 1'b0;
        g_wr = 1'b1;
      end
      pick_dm & ~dm_wr: begin
        g_rd = 1'b1;
        g_wr = 1'b0;
      end
      default: begin
        g_rd = 1'b1;
        g_wr = 1'b0;
      end
    endcase
  end

  // next state and per-state outputs
  always_comb begin
    state_n  = state;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    capture  = 1'b0;
    time_out = 1'b0;
    ctl_need = 1'b0;
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        tmo_load = 1'b1;
        if (grant) state_n = WAIT_START;
      end
      WAIT_START: begin
        ctl_need = 1'b1;
        tmo_en   = 1'b1;
        if (!ctl_done) begin
          state_n = WAIT_DONE;
        end else if (tmo_exp) begin
          state_n  = RESP;
          time_out = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (ctl_done) begin
          state_n = RESP;
          capture = ctl_rd;
        end
      end
      RESP: begin
        if_ack  = (port == PORT_IF);
        dm_ack  = (port == PORT_DM);
        err     = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // latch the granted request; op held through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port      <= PORT_IF;
      ctl_rd    <= 1'b0;
      ctl_wr    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
    end else if (grant) begin
      port      <= pick_dm ? PORT_DM : PORT_IF;
      ctl_rd    <= g_rd;
      ctl_wr    <= g_wr;
      ctl_addr  <= pick_dm ? dm_addr : if_addr;
      ctl_wdata <= pick_dm ? dm_wdata : '0;
    end else if (state == RESP) begin
      ctl_rd    <= 1'b0;
      ctl_wr    <= 1'b0;
    end
  end

  // remember a start timeout until its ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_q <= 1'b0;
    else if (grant)    err_q <= 1'b0;
    else if (time_out) err_q <= 1'b1;
  end

  // consecutive data grants made while fetch waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst <= '0;
    end else if (grant) begin
      if (pick_dm && if_req) burst <= burst + BW'(1);
      else                   burst <= '0;
    end
  end

  // read results land in the granted port only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (capture) begin
      if (port == PORT_DM) dm_rdata <= ctl_result;
      else                 if_rdata <= ctl_result;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// mem_arbiter bench: directed cases plus random
// two-master traffic against a memory reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        dm_rd = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        err;
  logic        ctl_need;
  logic        ctl_rd;
  logic        ctl_wr;
  logic [15:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic        ctl_done;
  logic [15:0] ctl_result;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .START_TIMEOUT(255),
    .MAX_DATA_BURST(2)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .err(err), .ctl_need(ctl_need),
    .ctl_rd(ctl_rd), .ctl_wr(ctl_wr),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_done(ctl_done), .ctl_result(ctl_result)
  );

  typedef struct {
    bit          upd;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] mdl_if = '0;
  logic [15:0] mdl_dm = '0;
  logic [15:0] cmem [0:65535];
  logic [15:0] ref_mem [logic [15:0]];

  int c_d1 = 0;
  int c_d2 = 0;
  bit c_rand = 1'b1;
  bit c_stuck = 1'b0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic world_set(input logic [15:0] a, input logic [15:0] d);
    cmem[a] = d;
    ref_mem[a] = d;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: pops one expectation per ack
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_ack || dm_ack || err)
        chk("one_ack", 32'(if_ack) + 32'(dm_ack), 1);
      if (if_ack) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_ack_unexpected got=ack want=none");
        end else begin
          e = if_q.pop_front();
          if (e.upd) mdl_if = e.data;
          chk("if_rdata", 32'(if_rdata), 32'(mdl_if));
          chk("if_err", 32'(err), 32'(e.err));
        end
      end
      if (dm_ack) begin
        if (dm_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dm_ack_unexpected got=ack want=none");
        end else begin
          e = dm_q.pop_front();
          if (e.upd) mdl_dm = e.data;
          chk("dm_rdata", 32'(dm_rdata), 32'(mdl_dm));
          chk("dm_err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  // controller model backed by a flat memory
  initial begin
    int d1;
    int d2;
    for (int i = 0; i < 65536; i++) cmem[i] = init_val(16'(i));
    ctl_done = 1'b1;
    ctl_result = '0;
    forever begin
      @(posedge clk); #1;
      if (ctl_need && !c_stuck && !rst) begin
        d1 = c_rand ? int'($urandom_range(3, 0)) : c_d1;
        d2 = c_rand ? int'($urandom_range(4, 0)) : c_d2;
        repeat (d1) begin @(posedge clk); #1; end
        ctl_done = 1'b0;
        repeat (d2 + 1) begin @(posedge clk); #1; end
        if (ctl_wr) cmem[ctl_addr] = ctl_wdata;
        ctl_result = ctl_rd ? cmem[ctl_addr] : 16'($urandom);
        ctl_done = 1'b1;
      end
    end
  end

  task automatic if_issue(input logic [15:0] a);
    exp_t e;
    e.upd = 1'b1; e.data = ref_rd(a); e.err = 1'b0;
    if_q.push_back(e);
    if_addr = a;
    if_req = 1'b1;
  endtask

  task automatic dm_issue(input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input bit terr);
    exp_t e;
    e.err = terr;
    if (wr) begin
      ref_mem[a] = d;
      e.upd = 1'b0; e.data = '0;
    end else begin
      e.upd = !terr; e.data = ref_rd(a);
    end
    dm_q.push_back(e);
    dm_addr = a; dm_wdata = d;
    dm_rd = rd; dm_wr = wr;
  endtask

  task automatic if_wait(output int ac);
    ac = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (if_ack) begin ac = cyc; break; end
    end
    if_req = 1'b0;
    if (ac < 0) begin
      checks++; failures++;
      $display("FAIL if_ack_wait got=none want=ack");
    end
  endtask

  task automatic dm_wait(output int ac);
    ac = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dm_ack) begin ac = cyc; break; end
    end
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    if (ac < 0) begin
      checks++; failures++;
      $display("FAIL dm_ack_wait got=none want=ack");
    end
  endtask

  task automatic wait_need(output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctl_need) begin c = cyc; break; end
    end
    if (c < 0) begin
      checks++; failures++;
      $display("FAIL ctl_need_wait got=none want=need");
    end
  endtask

  task automatic chk_zero();
    chk("rst_flags", 32'({if_ack, dm_ack, err, ctl_need,
        ctl_rd, ctl_wr, if_stall, dm_stall}), 0);
    chk("rst_ctl_addr", 32'(ctl_addr), 0);
    chk("rst_ctl_wdata", 32'(ctl_wdata), 0);
    chk("rst_if_rdata", 32'(if_rdata), 0);
    chk("rst_dm_rdata", 32'(dm_rdata), 0);
  endtask

  initial begin
    int ac;
    int c0;
    int nd;
    int n;
    int ord[$];
    int exp_ord[3];

    repeat (3) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    @(negedge clk);

    // data, data, then fetch under contention
    exp_ord = '{1, 1, 0};
    if_issue(16'h0040);
    dm_issue(1'b0, 1'b1, 16'h0104, 16'h7777, 1'b0);
    dm_issue(1'b0, 1'b1, 16'h0104, 16'h7777, 1'b0);
    nd = 0;
    for (int i = 0; i < 200 && ord.size() < 3; i++) begin
      @(negedge clk);
      if (dm_ack) ord.push_back(1);
      if (if_ack) ord.push_back(0);
    end
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    chk("burst_acks", 32'(ord.size()), 3);
    for (int i = 0; i < 3 && i < ord.size(); i++)
      chk("burst_order", 32'(ord[i]), 32'(exp_ord[i]));

    // UART read, start 2 cycles late, result BEEF
    world_set(UART_ADDR, 16'hBEEF);
    c_rand = 1'b0; c_d1 = 2; c_d2 = 1;
    @(negedge clk);
    dm_issue(1'b1, 1'b0, UART_ADDR, 16'h0, 1'b0);
    dm_wait(ac);
    chk("uart_if_keep", 32'(if_rdata), 32'(ref_rd(16'h0040)));
    @(negedge clk);
    chk("ack_pulse", 32'(dm_ack), 0);
    chk("uart_rdata", 32'(dm_rdata), 32'h0000BEEF);

    // both rd and wr: treated as write
    c_rand = 1'b1;
    dm_issue(1'b1, 1'b1, 16'h0108, 16'h1234, 1'b0);
    wait_need(c0);
    chk("rw_ctl_wr", 32'(ctl_wr), 1);
    chk("rw_ctl_rd", 32'(ctl_rd), 0);
    chk("rw_ctl_wdata", 32'(ctl_wdata), 32'h00001234);
    dm_wait(ac);
    dm_issue(1'b1, 1'b0, 16'h0108, 16'h0, 1'b0);
    dm_wait(ac);

    // controller never starts: timeout error
    c_stuck = 1'b1;
    dm_issue(1'b1, 1'b0, 16'h010A, 16'h0, 1'b1);
    wait_need(c0);
    dm_wait(ac);
    chk("timeout_lat", 32'(ac - c0), 256);
    c_stuck = 1'b0;
    @(negedge clk);

    // slow UART: long busy without error
    world_set(UART_ADDR, 16'hC0DE);
    c_rand = 1'b0; c_d1 = 0; c_d2 = 500;
    dm_issue(1'b1, 1'b0, UART_ADDR, 16'h0, 1'b0);
    wait_need(c0);
    dm_wait(ac);
    chk("uart_slow", 32'((ac - c0) > 500), 1);

    // reset while waiting for done
    c_d1 = 1; c_d2 = 20;
    @(negedge clk);
    dm_issue(1'b1, 1'b0, 16'h0102, 16'h0, 1'b0);
    for (int i = 0; i < 50 && ctl_done; i++) @(negedge clk);
    chk("rst_ctl_started", 32'(ctl_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero();
    dm_rd = 1'b0;
    dm_q.delete();
    if_q.delete();
    mdl_if = '0;
    mdl_dm = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (if_ack || dm_ack || err) n++;
    end
    chk("post_rst_ack", 32'(n), 0);
    c_rand = 1'b1;

    // random two-master traffic
    fork
      begin
        int fa;
        for (int k = 0; k < 40; k++) begin
          if_issue(16'($urandom_range(255, 0)));
          if_wait(fa);
          repeat ($urandom_range(3, 0)) @(negedge clk);
        end
      end
      begin
        int da;
        int op;
        logic [15:0] a;
        for (int k = 0; k < 40; k++) begin
          op = int'($urandom_range(2, 0));
          a = 16'h0100 + 16'($urandom_range(15, 0));
          dm_issue(op != 1, op != 0, a, 16'($urandom), 1'b0);
          dm_wait(da);
          repeat ($urandom_range(3, 0)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("if_q_empty", 32'(if_q.size()), 0);
    chk("dm_q_empty", 32'(dm_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
